// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst controller: FSM encoding,
// word/byte geometry, the 4 KB page limit and the AXI burst-length ceiling.
package dma_pkg;

  localparam int DMA_ADDR_W = 32;
  localparam int DMA_DATA_W = 32;
  localparam int DMA_LEN_W  = 8;
  localparam int DMA_CNT_W  = 16;

  localparam int DMA_BYTES      = DMA_DATA_W / 8;
  localparam int DMA_BYTE_SHIFT = $clog2(DMA_BYTES);

  // Bursts may not cross a 4 KB page, i.e. a change in address bits above 11.
  localparam int DMA_BOUND_BITS = 12;

  function automatic int dma_max_burst(input int len_w);
    return 1 << len_w;
  endfunction

  localparam int DMA_MAX_BURST = dma_max_burst(DMA_LEN_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_WAIT,
    ST_DONE
  } dma_state_e;

endpackage

// File: rtl/dma_burst_calc.sv
// Size of the next burst: min(words left, max burst, words left in the 4 KB page),
// returned both as a beat count and as the AXI length field (count - 1).
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int DATA_W = DMA_DATA_W,
  parameter int LEN_W  = DMA_LEN_W,
  parameter int CNT_W  = DMA_CNT_W
) (
  input  logic [CNT_W-1:0]                                   rem,
  input  logic [DMA_BOUND_BITS-$clog2(DATA_W/8)-1:0]         page_word,
  output logic [LEN_W:0]                                     words,
  output logic [LEN_W-1:0]                                   dma_len
);

  localparam int SHIFT = $clog2(DATA_W / 8);
  localparam int PW    = DMA_BOUND_BITS - SHIFT;
  localparam int RW    = PW + 1;
  localparam int WW    = LEN_W + 1;
  localparam int CW_A  = (CNT_W > RW) ? CNT_W : RW;
  localparam int CW    = (CW_A > WW) ? CW_A : WW;

  localparam logic [RW-1:0] ROOM_FULL = RW'(1) << PW;
  localparam logic [WW-1:0] MAX_L     = WW'(dma_max_burst(LEN_W));

  logic [RW-1:0] room;
  logic [WW-1:0] lim;

  always_comb begin
    room = ROOM_FULL - {1'b0, page_word};
    if (CW'(room) < CW'(MAX_L)) lim = WW'(room);
    else                        lim = MAX_L;
    if (CW'(rem) < CW'(lim)) words = WW'(rem);
    else                     words = lim;
    dma_len = LEN_W'(words - WW'(1));
  end

endmodule

// File: rtl/dma_burst_ctrl.sv
// Splits one transfer command into AXI-legal bursts and moves the words between
// the s_*/m_* streams and the engine's native word interface.
module dma_burst_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W,
  parameter int LEN_W  = DMA_LEN_W,
  parameter int CNT_W  = DMA_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dir,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    word_cnt,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_data,
  output logic                s_ready,
  output logic                m_valid,
  output logic [DATA_W-1:0]   m_data,
  input  logic                m_ready,
  output logic                valid,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ready,
  output logic [LEN_W-1:0]    dma_len,
  input  logic                dma_ready,
  input  logic                error,
  output dma_state_e          state_dbg
);

  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam logic [LEN_W:0] BEAT_ONE = (LEN_W+1)'(1);

  // Every stream here moves a word only in a cycle where valid & ready are both
  // high; a source that raised valid keeps it and its data until that happens.

  dma_state_e          state_q, state_d;
  logic                dir_q, dir_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [LEN_W:0]      beat_q, beat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mvld_q, mvld_d;
  logic [DATA_W-1:0]   mbuf_q, mbuf_d;

  logic [LEN_W:0]      calc_words;
  logic [LEN_W-1:0]    calc_len;
  logic                hs;
  logic                drain;

  dma_burst_calc #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) u_calc (
    .rem       (rem_q),
    .page_word (addr_q[DMA_BOUND_BITS-1:SHIFT]),
    .words     (calc_words),
    .dma_len   (calc_len)
  );

  // Native request side; an engine error kills the request in the same cycle.
  always_comb begin
    valid   = 1'b0;
    s_ready = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    if (state_q == ST_XFER && !error) begin
      if (dir_q) begin
        valid   = s_valid;
        s_ready = ready;
        wdata   = s_data;
        wstrb   = '1;
      end else begin
        valid = !mvld_q || m_ready;
      end
    end
  end

  assign hs    = valid && ready;
  assign drain = mvld_q && m_ready;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    len_d   = len_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mvld_d  = mvld_q && !drain;
    mbuf_d  = mbuf_q;

    if (hs) begin
      addr_d = addr_q + ADDR_W'(BYTES);
      rem_d  = rem_q - CNT_W'(1);
      beat_d = beat_q - BEAT_ONE;
      if (!dir_q) begin
        mvld_d = 1'b1;
        mbuf_d = rdata;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d   = dir;
          addr_d  = base_addr & ~ADDR_W'(BYTES - 1);
          rem_d   = word_cnt;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (word_cnt == '0) ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (dma_ready) begin
          len_d   = calc_len;
          beat_d  = calc_words;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (hs && beat_q == BEAT_ONE) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dma_ready) state_d = (rem_q != '0) ? ST_SETUP : ST_DONE;
      end
      ST_DONE: begin
        // Reads finish only once the last word has left the output buffer.
        if (dir_q || !mvld_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (error && (state_q inside {ST_SETUP, ST_XFER, ST_WAIT})) begin
      err_d   = 1'b1;
      mvld_d  = 1'b0;
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mvld_q  <= 1'b0;
      mbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mvld_q  <= mvld_d;
      mbuf_q  <= mbuf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign m_valid   = mvld_q;
  assign m_data    = mbuf_q;
  assign address   = addr_q;
  assign dma_len   = len_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Randomized bench for dma_burst_ctrl: a command-level model predicts every
// native beat and read word, and a monitor compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_dma_burst_ctrl;
  import dma_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, dir;
  logic [31:0] base_addr;
  logic [15:0] word_cnt;
  logic        busy, done, err;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [31:0] s_data, m_data;
  logic        valid, ready, dma_ready, error;
  logic [31:0] address, wdata, rdata;
  logic [3:0]  wstrb;
  logic [7:0]  dma_len;
  dma_state_e  state_dbg;

  dma_burst_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .base_addr(base_addr),
    .word_cnt(word_cnt), .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .dma_len(dma_len), .dma_ready(dma_ready),
    .error(error), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_len_q[$];
  logic [31:0] exp_wdata_q[$];
  logic [31:0] exp_mdata_q[$];
  logic [31:0] src_q[$];
  int  beats_seen = 0;
  int  done_seen = 0;
  int  cmd_done_base = 0;
  bit  cur_dir = 1'b0;
  bit  s_acc = 1'b0;
  int  ready_pct = 100, dma_ready_pct = 100, s_valid_pct = 100, m_ready_mode = 0;
  int  err_at_beat = 0;
  bit  err_fired = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command-level reference: walk the transfer, cut bursts at 256 words or a 4 KB page.
  task automatic model_cmd(input bit d, input logic [31:0] base, input int cnt);
    logic [31:0] a;
    logic [31:0] w;
    int left, room, n;
    a = base & 32'hFFFF_FFFC;
    left = cnt;
    while (left > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      n = left;
      if (n > 256) n = 256;
      if (n > room) n = room;
      for (int i = 0; i < n; i++) begin
        exp_addr_q.push_back(a);
        exp_len_q.push_back(8'(n - 1));
        if (d) begin
          w = $urandom;
          src_q.push_back(w);
          exp_wdata_q.push_back(w);
        end else begin
          exp_mdata_q.push_back(mem_word(a));
        end
        a = a + 32'd4;
      end
      left -= n;
    end
  endtask

  task automatic flush_all();
    exp_addr_q.delete();
    exp_len_q.delete();
    exp_wdata_q.delete();
    exp_mdata_q.delete();
    src_q.delete();
    s_acc = 1'b0;
  endtask

  // ---------------- engine + stream drivers ----------------
  initial begin : drivers
    logic [31:0] dump;
    ready = 1'b0; dma_ready = 1'b0; error = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (s_acc) begin
        if (src_q.size() > 0) dump = src_q.pop_front();
        s_valid = 1'b0;
        s_acc = 1'b0;
      end
      if (src_q.size() == 0) s_valid = 1'b0;
      else if (!s_valid && $urandom_range(99) < s_valid_pct) s_valid = 1'b1;
      s_data = (src_q.size() > 0) ? src_q[0] : 32'h0;
      ready = ($urandom_range(99) < ready_pct);
      dma_ready = ($urandom_range(99) < dma_ready_pct);
      rdata = mem_word(address);
      case (m_ready_mode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        default: m_ready = ($urandom_range(1) == 1);
      endcase
      error = 1'b0;
      if (rst && err_at_beat != 0 && !err_fired && beats_seen == err_at_beat - 1) begin
        error = 1'b1;
        err_fired = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        if (error) begin
          check("valid_low_on_error", valid, 0);
          check("s_ready_low_on_error", s_ready, 0);
        end
        if (valid && ready) begin
          beats_seen++;
          if (exp_addr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_beat: got beat at 0x%0h expected none", address);
          end else begin
            check("beat_address", address, exp_addr_q.pop_front());
            check("beat_dma_len", dma_len, exp_len_q.pop_front());
            check("beat_wstrb", wstrb, cur_dir ? 4'hF : 4'h0);
            if (cur_dir) begin
              if (exp_wdata_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_wdata: got 0x%0h expected none", wdata);
              end else check("beat_wdata", wdata, exp_wdata_q.pop_front());
            end
          end
        end
        if (s_valid && s_ready) s_acc = 1'b1;
        if (m_valid && m_ready) begin
          if (exp_mdata_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_read_word: got 0x%0h expected none", m_data);
          end else check("read_word", m_data, exp_mdata_q.pop_front());
        end
        if (done) begin
          done_seen++;
          check("busy_low_at_done", busy, 0);
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic set_env(input int rp, input int drp, input int svp, input int mrm);
    ready_pct = rp; dma_ready_pct = drp; s_valid_pct = svp; m_ready_mode = mrm;
  endtask

  task automatic issue(input bit d, input logic [31:0] base, input int cnt);
    beats_seen = 0;
    cur_dir = d;
    cmd_done_base = done_seen;
    model_cmd(d, base, cnt);
    @(posedge clk); #1;
    start = 1'b1; dir = d; base_addr = base; word_cnt = 16'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input int budget, input bit exp_err, input int exp_beats);
    int n;
    n = 0;
    while (done_seen == cmd_done_base && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_done_pulses"}, done_seen - cmd_done_base, 1);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy_clear"}, busy, 0);
    check({tag, "_beat_count"}, beats_seen, exp_beats);
    if (!exp_err) begin
      check({tag, "_beats_left"}, exp_addr_q.size(), 0);
      check({tag, "_read_words_left"}, exp_mdata_q.size(), 0);
    end
    flush_all();
    repeat (2) @(posedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl_bits"}, {valid, s_ready, busy, done, err, m_valid}, 0);
    check({tag, "_address"}, address, 0);
    check({tag, "_dma_len"}, dma_len, 0);
    check({tag, "_wdata_wstrb"}, {wdata, wstrb}, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_state"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n, cnt;
    logic [31:0] base;
    bit d;
    rst = 1'b0; start = 1'b0; dir = 1'b0; base_addr = '0; word_cnt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // single burst at full speed, with a start that must be ignored mid-transfer
    set_env(100, 100, 100, 0);
    issue(1'b1, 32'h100, 8);
    repeat (2) @(posedge clk); #1;
    start = 1'b1; dir = 1'b0; base_addr = 32'h2000; word_cnt = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    check("busy_during_ignored_start", busy, 1);
    finish_cmd("w100_8", 200, 1'b0, 8);

    // 256 + 44 split with a stalling source and engine
    set_env(70, 100, 60, 0);
    issue(1'b1, 32'h0, 300);
    finish_cmd("w0_300", 4000, 1'b0, 300);

    // read across a 4 KB page with m_ready toggling
    set_env(100, 100, 100, 1);
    issue(1'b0, 32'hFF0, 20);
    finish_cmd("r_ff0_20", 400, 1'b0, 20);

    // zero-length command: done exactly 2 cycles after start, no beats
    set_env(100, 100, 100, 0);
    issue(1'b1, 32'h40, 0);
    @(negedge clk); #1;
    check("cnt0_done_not_yet", done, 0);
    check("cnt0_busy", busy, 1);
    @(negedge clk); #1;
    check("cnt0_done_pulse", done, 1);
    finish_cmd("cnt0", 10, 1'b0, 0);

    // engine error on the third beat, then a fresh start clears err
    set_env(100, 100, 100, 0);
    err_fired = 1'b0;
    err_at_beat = 3;
    issue(1'b1, 32'h200, 16);
    finish_cmd("err_w16", 100, 1'b1, 2);
    err_at_beat = 0;
    issue(1'b1, 32'h300, 4);
    @(negedge clk); #1;
    check("err_cleared_by_start", err, 0);
    finish_cmd("after_err", 100, 1'b0, 4);

    // asynchronous reset mid-burst, then a normal command
    issue(1'b1, 32'h0, 64);
    n = 0;
    while (beats_seen < 5 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("reached_mid_burst", beats_seen >= 5, 1);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    flush_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    issue(1'b1, 32'h80, 10);
    finish_cmd("post_reset", 200, 1'b0, 10);

    // read that wraps the top of the address space
    set_env(100, 100, 100, 1);
    issue(1'b0, 32'hFFFF_FFF0, 8);
    finish_cmd("r_wrap", 200, 1'b0, 8);

    // randomized commands
    for (int k = 0; k < 6; k++) begin
      d = ($urandom_range(1) == 1);
      base = $urandom & 32'h0000_3FFF;
      if ($urandom_range(2) == 0) base = {base[31:12], 12'hF00} | ($urandom & 32'h3);
      cnt = $urandom_range(1, 300);
      set_env($urandom_range(50, 100), $urandom_range(60, 100), $urandom_range(50, 100), 2);
      issue(d, base, cnt);
      finish_cmd($sformatf("rand%0d", k), 30 * cnt + 200, 1'b0, cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #800_000;
    failures++;
    $display("FAIL watchdog: got no end of test expected completion within 80000 cycles");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
